// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2308-style SAR ADC frame controller:
// FSM state encoding, configuration-word bit positions and default sizes.
package adc_pkg;

   localparam int DATA_W_DEF      = 12;
   localparam int CFG_W_DEF       = 6;
   localparam int CONV_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Bit positions inside the 6-bit configuration word (MSB goes out first).
   localparam int CFG_SD  = 5;
   localparam int CFG_OS  = 4;
   localparam int CFG_S1  = 3;
   localparam int CFG_S0  = 2;
   localparam int CFG_UNI = 1;
   localparam int CFG_SLP = 0;

   // Single-ended, unipolar, awake; channel address split over O/S, S1, S0.
   function automatic logic [CFG_W_DEF-1:0] cfg_word(input logic [2:0] ch);
      logic [CFG_W_DEF-1:0] w;
      w          = '0;
      w[CFG_SD]  = 1'b1;
      w[CFG_OS]  = ch[0];
      w[CFG_S1]  = ch[2];
      w[CFG_S0]  = ch[1];
      w[CFG_UNI] = 1'b1;
      w[CFG_SLP] = 1'b0;
      return w;
   endfunction

endpackage

// File: rtl/adc_sample_ctrl.sv
// Frame controller for an LTC2308-style 12-bit SAR ADC. Each frame pulses
// CONVST, then clocks DATA_W SCK periods (clk/2) shifting the next channel
// config out on SDI while the previous conversion result comes in on SDO.
// The result is presented with a one-cycle strobe tagged with the channel
// that was configured one frame earlier.
module adc_sample_ctrl
   import adc_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int CFG_W       = CFG_W_DEF,
   parameter int CONV_CYCLES = CONV_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pll_locked,
   input  logic              start,
   input  logic [2:0]        ch_sel,
   input  logic              adc_sdo,
   output logic              adc_convst,
   output logic              adc_sck,
   output logic              adc_sdi,
   output logic              busy,
   output logic              sample_valid,
   output logic [DATA_W-1:0] sample_data,
   output logic [2:0]        sample_ch
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CNT_W = $clog2(CONV_CYCLES + 1);

   state_t              state_q;
   logic [CNT_W-1:0]    conv_cnt_q;
   logic [BIT_W-1:0]    bit_cnt_q;
   logic                phase_q;
   logic [2:0]          next_ch_q;
   logic [2:0]          prev_ch_q;
   logic                first_frame_q;
   logic [DATA_W-1:0]   cfg_sh_q;
   logic [DATA_W-1:0]   res_sh_q;
   logic                convst_q;
   logic                sck_q;
   logic                sdi_q;
   logic                busy_q;
   logic                valid_q;
   logic [DATA_W-1:0]   data_q;
   logic [2:0]          ch_q;
   logic                abort;

   // Losing PLL lock while the ADC is being driven cancels the frame.
   assign abort = !pll_locked && (state_q == ST_CONV || state_q == ST_SHIFT);

   // Frame FSM with bit counter, SCK phase, config/result shifters and
   // registered ADC and sample outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         conv_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         phase_q       <= 1'b0;
         prev_ch_q     <= '0;
         first_frame_q <= 1'b1;
         convst_q      <= 1'b0;
         sck_q         <= 1'b0;
         sdi_q         <= 1'b0;
         busy_q        <= 1'b0;
         valid_q       <= 1'b0;
         data_q        <= '0;
         ch_q          <= '0;
      end else begin
         valid_q <= 1'b0;
         if (abort) begin
            // Result of an interrupted frame is unusable, and so is the
            // config the ADC may or may not have latched.
            state_q       <= ST_IDLE;
            convst_q      <= 1'b0;
            sck_q         <= 1'b0;
            sdi_q         <= 1'b0;
            busy_q        <= 1'b0;
            first_frame_q <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start && pll_locked) begin
                     state_q    <= ST_CONV;
                     convst_q   <= 1'b1;
                     busy_q     <= 1'b1;
                     conv_cnt_q <= CNT_W'(CONV_CYCLES - 1);
                     next_ch_q  <= ch_sel;
                     // Config left-aligned in the frame; trailing SCKs send 0.
                     cfg_sh_q   <= DATA_W'(cfg_word(ch_sel)) << (DATA_W - CFG_W);
                  end
               end
               ST_CONV: begin
                  if (conv_cnt_q == '0) begin
                     state_q   <= ST_SHIFT;
                     convst_q  <= 1'b0;
                     sdi_q     <= cfg_sh_q[DATA_W-1];
                     cfg_sh_q  <= cfg_sh_q << 1;
                     bit_cnt_q <= BIT_W'(DATA_W - 1);
                     phase_q   <= 1'b0;
                  end else begin
                     conv_cnt_q <= conv_cnt_q - 1'b1;
                  end
               end
               ST_SHIFT: begin
                  if (!phase_q) begin
                     // SDO is captured on the edge that raises SCK.
                     res_sh_q <= {res_sh_q[DATA_W-2:0], adc_sdo};
                     phase_q  <= 1'b1;
                     sck_q    <= 1'b1;
                  end else if (bit_cnt_q == '0) begin
                     state_q       <= ST_DONE;
                     sck_q         <= 1'b0;
                     sdi_q         <= 1'b0;
                     valid_q       <= !first_frame_q;
                     data_q        <= res_sh_q;
                     ch_q          <= prev_ch_q;
                     prev_ch_q     <= next_ch_q;
                     first_frame_q <= 1'b0;
                  end else begin
                     // SDI only moves together with the falling SCK edge.
                     bit_cnt_q <= bit_cnt_q - 1'b1;
                     phase_q   <= 1'b0;
                     sck_q     <= 1'b0;
                     sdi_q     <= cfg_sh_q[DATA_W-1];
                     cfg_sh_q  <= cfg_sh_q << 1;
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign adc_convst   = convst_q;
   assign adc_sck      = sck_q;
   assign adc_sdi      = sdi_q;
   assign busy         = busy_q;
   assign sample_valid = valid_q;
   assign sample_data  = data_q;
   assign sample_ch    = ch_q;

endmodule

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

- Frame controller for the board's LTC2308-style 12-bit SAR ADC.
- Runs in the 1.171875 MHz domain produced by the on-chip PLL and stays idle until the PLL reports lock.
- Per request, it starts a conversion, shifts out the next channel configuration, shifts in the previous result, and presents it as a one-cycle valid sample.
- It sits directly downstream of the PLL and upstream of the sample consumer logic.

## Interface
Parameters:
- DATA_W, 12: ADC result width and SCK bit count per frame.
- CFG_W, 6: configuration word width shifted on SDI.
- CONV_CYCLES, 2: clk cycles CONVST is held high; must cover tCONV of 1.6 µs (2 × 853 ns).

Ports:
- clk  in  1: PLL output clock (1.171875 MHz); the only clock.
- rst  in  1: synchronous reset, active-high.
- pll_locked  in  1: PLL lock; treated as level-qualified enable, already in clk domain.
- start  in  1: frame request, sampled in IDLE only.
- ch_sel  in  3: channel for the conversion after this frame.
- adc_sdo  in  1: ADC serial data out.
- adc_convst  out  1: conversion start.
- adc_sck  out  1: serial clock, clk/2.
- adc_sdi  out  1: serial config data.
- busy  out  1: frame in progress.
- sample_valid  out  1: one-cycle strobe.
- sample_data  out  DATA_W: result, valid with strobe.
- sample_ch  out  3: channel the result belongs to.

## Operation
- States: IDLE, CONV, SHIFT, DONE.
- **IDLE:**
  - Enter CONV when start=1 and pll_locked=1.
  - Latch ch_sel into next_ch.
  - Build cfg = {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0}, MSB first.
- **CONV:** adc_convst=1 for CONV_CYCLES cycles, then go to SHIFT with adc_convst=0.
- **SHIFT:** 2·DATA_W cycles; bit counter counts DATA_W-1 down to 0; phase toggles each cycle.
  - Phase 0: adc_sck=0; adc_sdi = cfg bit (bits beyond CFG_W drive 0).
  - Phase 1: adc_sck=1.
  - adc_sdo is shifted into the result register, MSB first, at the clk edge ending phase 0.
  - After phase 1 of bit 0, go to DONE.
- **DONE (1 cycle):**
  - sample_valid=1, unless first_frame is set.
  - sample_data = shift register.
  - sample_ch = prev_ch, the channel configured by the previous frame.
  - prev_ch ← next_ch; first_frame ← 0.
  - Return to IDLE.
- **first_frame:**
  - Set by rst and by any abort.
  - Suppresses sample_valid in DONE, because that frame's result belongs to an unknown config.
  - The frame still runs and still updates prev_ch.
- **Abort:** pll_locked=0 in CONV or SHIFT forces the next state to IDLE.
  - adc_convst, adc_sck and adc_sdi go to 0.
  - No sample_valid is produced; first_frame is set.
- **start handling:** start outside IDLE is ignored; it is not queued. start held high in IDLE back-to-back gives continuous frames separated by one IDLE cycle.
- **Reset values:**
  - adc_convst=0, adc_sck=0, adc_sdi=0, busy=0, sample_valid=0.
  - sample_data=0, sample_ch=0, prev_ch=0, first_frame=1, state=IDLE.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- start sampled high at edge k:
  - adc_convst=1 in cycles k+1 … k+CONV_CYCLES.
  - First adc_sck rise in cycle k+CONV_CYCLES+2.
  - Last adc_sck high in cycle k+CONV_CYCLES+2·DATA_W.
  - sample_valid in cycle k+CONV_CYCLES+2·DATA_W+1, i.e. 27 cycles at defaults.
- busy=1 from cycle k+1 through the DONE cycle inclusive.
- Frame period with start held high: CONV_CYCLES+2·DATA_W+2 = 28 cycles, ≈23.9 µs (≈41.9 kS/s).
- adc_sdi changes only while adc_sck=0; adc_sck high pulse is exactly 1 clk.
- pll_locked low during IDLE: start is ignored and busy stays 0.

## Structure
- Shared package adc_pkg holds:
  - State enum.
  - Config bit positions (SD, OS, S1, S0, UNI, SLP).
  - Function mapping a 3-bit channel to the 6-bit cfg word.
  - Default DATA_W, CFG_W and CONV_CYCLES constants.
- No sub-module: FSM, bit counter, phase bit and the two shift registers fit in one module.

## Test plan
- **Reset then start, ADC model returns 0xA5C, ch_sel=3:** frame completes with no sample_valid (first_frame). Second start with ch_sel=5 gives sample_valid, sample_data=0xA5C, sample_ch=3.
- **SDI check, ch_sel=6:** bits captured on the first 6 adc_sck rises are 1,0,1,1,1,0; the remaining 6 are 0.
- **Cycle count:** start pulse at cycle 0 gives adc_convst high in cycles 1–2, 12 SCK pulses, and sample_valid exactly at cycle 27. busy is high in cycles 1–27.
- **pll_locked dropped at SCK bit 4:**
  - Next cycle: state IDLE, all ADC outputs 0, busy=0, no sample_valid.
  - After relock, the following frame is suppressed (first_frame).
- **start held high for 3 frames, locked:** frames are 28 cycles apart; sample_valid appears in frames 2 and 3 only.
- **rst asserted mid-SHIFT:** next cycle all outputs equal their reset values; a start in the same cycle as rst is ignored.
